gpredict_ctrl: RTL and testbench

- Controller and scheduler for the single-ported 16-entry 2-bit BHT of the global predictor.
- Shares the BHT port between predict lookups and resolve updates.
- Keeps speculative and committed 4-bit GHRs, tracks in-flight branches in an in-order queue, and repairs the GHR and flushes on mispredict.
- After reset, sequences a BHT initialisation sweep before any lookup is allowed.

---
 rtl/gpredict_pkg.sv | 27 ++
 rtl/gpredict_inflight_q.sv | 50 +++++
 rtl/gpredict_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_gpredict_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/gpredict_pkg.sv
// Shared types, constants and the 2-bit saturating counter update for the
// global-history branch predictor controller.
package gpredict_pkg;

  localparam int              CNT_W        = 2;
  localparam logic [CNT_W-1:0] CNT_MIN      = 2'd0;
  localparam logic [CNT_W-1:0] CNT_MAX      = 2'd3;
  // Weakly not-taken: the value every BHT entry holds after the init sweep.
  localparam logic [CNT_W-1:0] BHT_INIT_VAL = 2'b01;
  // Width of the index field stored per in-flight branch; GHR_W must not exceed it.
  localparam int              IDX_W        = 4;

  typedef enum logic [1:0] {INIT, IDLE, UPD_RD, UPD_WR} state_t;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic             pred;
  } q_entry_t;

  // Saturating 2-bit counter step: taken counts up to 3, not-taken down to 0.
  function automatic logic [CNT_W-1:0] sat_update(input logic [CNT_W-1:0] c,
                                                  input logic             taken);
    if (taken) return (c == CNT_MAX) ? c : c + CNT_W'(1);
    else       return (c == CNT_MIN) ? c : c - CNT_W'(1);
  endfunction

endpackage

// File: rtl/gpredict_inflight_q.sv
// In-order queue of in-flight branches. Pointers carry an extra wrap bit so
// full and empty are distinguishable; clear drops everything after the head pop.
module gpredict_inflight_q
  import gpredict_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  q_entry_t      i_push_data,
  input  logic          i_pop,
  input  logic          i_clr,
  output logic          o_full,
  output logic          o_empty,
  output q_entry_t      o_head,
  output logic [AW-1:0] o_wr_tag
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] r_rd, r_wr;
  logic [AW:0] w_rd_nxt;
  q_entry_t    r_mem [DEPTH];

  assign w_rd_nxt = i_pop ? r_rd + PTR_ONE : r_rd;
  assign o_empty  = (r_wr == r_rd);
  assign o_full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_head   = r_mem[r_rd[AW-1:0]];
  assign o_wr_tag = r_wr[AW-1:0];

  // Pointer update; a clear collapses the write pointer onto the post-pop head.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd <= '0;
      r_wr <= '0;
    end else begin
      r_rd <= w_rd_nxt;
      if (i_clr)       r_wr <= w_rd_nxt;
      else if (i_push) r_wr <= r_wr + PTR_ONE;
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/gpredict_ctrl.sv
// Global predictor controller: sweeps the BHT after reset, then arbitrates the
// single BHT port between predict lookups and two-cycle resolve updates,
// keeping speculative/committed history and flushing on mispredict.
module gpredict_ctrl
  import gpredict_pkg::*;
#(
  parameter  int               GHR_W      = IDX_W,
  parameter  int               DEPTH      = 4,
  parameter  logic [CNT_W-1:0] INIT_VAL   = BHT_INIT_VAL,
  parameter  bit               USE_PC_XOR = 1'b0,
  localparam int               AW         = $clog2(DEPTH)
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_req,
  input  logic [7:0]       pred_pc,
  output logic             pred_gnt,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [AW-1:0]    pred_tag,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             res_ready,
  output logic             flush,
  output logic             init_done,
  output logic [GHR_W-1:0] bht_idx,
  input  logic [CNT_W-1:0] bht_rdata,
  output logic             bht_we,
  output logic [CNT_W-1:0] bht_wdata
);

  state_t               r_state, w_state_nxt;
  logic [GHR_W-1:0]     r_sweep;
  logic                 r_init_done;
  logic [GHR_W-1:0]     r_spec_ghr, r_commit_ghr;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_res_taken;
  logic                 r_pred_valid, r_pred_taken;
  logic [AW-1:0]        r_pred_tag;

  logic [GHR_W-1:0]     w_lidx, w_head_idx, w_commit_nxt;
  logic [GHR_W-1:0]     w_bht_idx;
  logic [CNT_W-1:0]     w_bht_wdata;
  logic                 w_bht_we, w_gnt, w_res_ready, w_res_hs, w_pop, w_flush;
  logic                 w_q_full, w_q_empty;
  logic [AW-1:0]        w_wr_tag;
  q_entry_t             w_head, w_push_data;

  assign w_lidx       = USE_PC_XOR ? (r_spec_ghr ^ pred_pc[GHR_W-1:0]) : r_spec_ghr;
  assign w_head_idx   = GHR_W'(w_head.index);
  assign w_commit_nxt = {r_commit_ghr[GHR_W-2:0], r_res_taken};
  assign w_push_data  = '{index: IDX_W'(w_lidx), pred: bht_rdata[1]};

  gpredict_inflight_q #(.DEPTH(DEPTH)) u_q (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_gnt),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_clr       (w_flush),
    .o_full      (w_q_full),
    .o_empty     (w_q_empty),
    .o_head      (w_head),
    .o_wr_tag    (w_wr_tag)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= INIT;
    else       r_state <= w_state_nxt;
  end

  // Next state and BHT port / handshake decode; everything is held low in reset.
  always_comb begin
    w_state_nxt = r_state;
    w_bht_idx   = '0;
    w_bht_we    = 1'b0;
    w_bht_wdata = '0;
    w_gnt       = 1'b0;
    w_res_ready = 1'b0;
    w_res_hs    = 1'b0;
    w_pop       = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      INIT: begin
        w_bht_we    = 1'b1;
        w_bht_idx   = r_sweep;
        w_bht_wdata = INIT_VAL;
        if (&r_sweep) w_state_nxt = IDLE;
      end
      IDLE: begin
        w_bht_idx   = w_lidx;
        w_res_ready = !w_q_empty;
        w_res_hs    = w_res_ready && res_valid;
        w_gnt       = pred_req && !w_q_full && !w_res_hs;
        if (w_res_hs) w_state_nxt = UPD_RD;
      end
      UPD_RD: begin
        w_bht_idx   = w_head_idx;
        w_state_nxt = UPD_WR;
      end
      UPD_WR: begin
        w_bht_idx   = w_head_idx;
        w_bht_we    = 1'b1;
        w_bht_wdata = sat_update(r_cnt, r_res_taken);
        w_pop       = 1'b1;
        w_flush     = (r_res_taken != w_head.pred);
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = INIT;
    endcase
    if (reset) begin
      w_bht_idx   = '0;
      w_bht_we    = 1'b0;
      w_bht_wdata = '0;
      w_gnt       = 1'b0;
      w_res_ready = 1'b0;
      w_res_hs    = 1'b0;
      w_pop       = 1'b0;
      w_flush     = 1'b0;
    end
  end

  // Init sweep counter and the sticky init_done flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sweep     <= '0;
      r_init_done <= 1'b0;
    end else if (r_state == INIT) begin
      r_sweep <= r_sweep + GHR_W'(1);
      if (&r_sweep) r_init_done <= 1'b1;
    end
  end

  // History registers: speculative shifts on grant, repaired from commit on flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_spec_ghr   <= '0;
      r_commit_ghr <= '0;
    end else if (r_state == UPD_WR) begin
      r_commit_ghr <= w_commit_nxt;
      if (w_flush) r_spec_ghr <= w_commit_nxt;
    end else if (w_gnt) begin
      r_spec_ghr <= {r_spec_ghr[GHR_W-2:0], bht_rdata[1]};
    end
  end

  // Resolve datapath: outcome captured at handshake, counter captured in UPD_RD.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_res_taken <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_res_hs)            r_res_taken <= res_taken;
      if (r_state == UPD_RD)   r_cnt       <= bht_rdata;
    end
  end

  // Predict response, one cycle after the grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_tag   <= '0;
    end else begin
      r_pred_valid <= w_gnt;
      if (w_gnt) begin
        r_pred_taken <= bht_rdata[1];
        r_pred_tag   <= w_wr_tag;
      end
    end
  end

  assign pred_gnt   = w_gnt;
  assign pred_valid = r_pred_valid;
  assign pred_taken = r_pred_taken;
  assign pred_tag   = r_pred_tag;
  assign res_ready  = w_res_ready;
  assign flush      = w_flush;
  assign init_done  = r_init_done;
  assign bht_idx    = w_bht_idx;
  assign bht_we     = w_bht_we;
  assign bht_wdata  = w_bht_wdata;

endmodule

// File: tb/tb_gpredict_ctrl.sv
// Randomized bench for gpredict_ctrl against a transaction-level predictor model.
module tb_gpredict_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pred_req = 1'b0;
  logic [7:0] pred_pc = '0;
  logic       res_valid = 1'b0;
  logic       res_taken = 1'b0;
  logic       pred_gnt, pred_valid, pred_taken, res_ready, flush, init_done, bht_we;
  logic [1:0] pred_tag;
  logic [3:0] bht_idx;
  logic [1:0] bht_rdata, bht_wdata;

  logic [1:0] bht_ram [16];

  always #5 clk = ~clk;

  // BHT memory: combinational read, write on the rising edge.
  assign bht_rdata = bht_ram[bht_idx];
  always @(posedge clk) if (bht_we) bht_ram[bht_idx] <= bht_wdata;

  gpredict_ctrl #(.GHR_W(4), .DEPTH(DEPTH), .INIT_VAL(2'b01), .USE_PC_XOR(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .pred_req   (pred_req),
    .pred_pc    (pred_pc),
    .pred_gnt   (pred_gnt),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .pred_tag   (pred_tag),
    .res_valid  (res_valid),
    .res_taken  (res_taken),
    .res_ready  (res_ready),
    .flush      (flush),
    .init_done  (init_done),
    .bht_idx    (bht_idx),
    .bht_rdata  (bht_rdata),
    .bht_we     (bht_we),
    .bht_wdata  (bht_wdata)
  );

  // Reference model state
  typedef struct { int idx; int pred; } ent_t;
  ent_t mq[$];
  int   m_bht [16];
  int   m_spec, m_commit, m_wr, m_rd;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int c, input bit t);
    if (t) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
    mq.delete();
    m_spec = 0; m_commit = 0; m_wr = 0; m_rd = 0;
  endtask

  // Called at the negedge where reset has just been released.
  task automatic sweep();
    pred_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("sweep_we", bht_we, 1);
      chk("sweep_idx", bht_idx, i);
      chk("sweep_wdata", bht_wdata, 1);
      chk("sweep_gnt", pred_gnt, 0);
      chk("sweep_ready", res_ready, 0);
      chk("sweep_done", init_done, 0);
      @(negedge clk);
    end
    pred_req = 1'b0;
    #1;
    chk("init_done", init_done, 1);
    chk("idle_we", bht_we, 0);
    model_reset();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; pred_req = 1'b1; res_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_we", bht_we, 0);
    chk("rst_gnt", pred_gnt, 0);
    chk("rst_ready", res_ready, 0);
    chk("rst_pvalid", pred_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_done", init_done, 0);
    @(negedge clk);
    reset = 1'b0; res_valid = 1'b0;
    sweep();
  endtask

  // One IDLE-cycle transaction; entered and left at an IDLE-cycle negedge.
  task automatic step(input int pct_pred, input int pct_res, input int pct_taken);
    bit   dp, dr, tk, hs, g;
    int   exp_pred, exp_tag, exp_w;
    ent_t h;
    dp = ($urandom_range(99) < pct_pred);
    dr = ($urandom_range(99) < pct_res);
    tk = ($urandom_range(99) < pct_taken);
    pred_req = dp; pred_pc = 8'($urandom); res_valid = dr; res_taken = tk;
    #1;
    hs = dr && (mq.size() > 0);
    g  = dp && !hs && (mq.size() < DEPTH);
    chk("res_ready", res_ready, mq.size() > 0);
    chk("pred_gnt", pred_gnt, g);
    chk("idle_flush", flush, 0);
    chk("idle_we", bht_we, 0);
    chk("lookup_idx", bht_idx, m_spec);
    exp_pred = 0; exp_tag = 0;
    if (g) begin
      exp_pred = m_bht[m_spec] >> 1;
      exp_tag  = m_wr % DEPTH;
      mq.push_back('{m_spec, exp_pred});
      m_wr++;
      m_spec = ((m_spec << 1) | exp_pred) & 15;
    end
    @(negedge clk);
    #1;
    chk("pred_valid", pred_valid, g);
    if (g) begin
      chk("pred_taken", pred_taken, exp_pred);
      chk("pred_tag", pred_tag, exp_tag);
    end
    if (hs) begin
      h = mq[0];
      chk("updrd_idx", bht_idx, h.idx);
      chk("updrd_we", bht_we, 0);
      chk("updrd_ready", res_ready, 0);
      chk("updrd_gnt", pred_gnt, 0);
      @(negedge clk);
      #1;
      exp_w = sat(m_bht[h.idx], tk);
      chk("updwr_we", bht_we, 1);
      chk("updwr_idx", bht_idx, h.idx);
      chk("updwr_wdata", bht_wdata, exp_w);
      chk("updwr_flush", flush, (tk != h.pred));
      chk("updwr_gnt", pred_gnt, 0);
      chk("updwr_pvalid", pred_valid, 0);
      m_bht[h.idx] = exp_w;
      m_commit = ((m_commit << 1) | tk) & 15;
      void'(mq.pop_front());
      m_rd++;
      if (tk != h.pred) begin
        mq.delete();
        m_wr   = m_rd;
        m_spec = m_commit;
      end
      @(negedge clk);
    end
  endtask

  // Reset landing on the first update cycle must suppress the port and restart the sweep.
  task automatic reset_in_update();
    pred_req = 1'b0; res_valid = 1'b1; res_taken = 1'b0;
    #1;
    chk("rupd_ready", res_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rupd_we", bht_we, 0);
    @(negedge clk);
    reset = 1'b0; res_valid = 1'b0;
    sweep();
  endtask

  initial begin
    apply_reset();
    for (int i = 0; i < 150; i++) step(70, 35, 85);
    for (int i = 0; i < 150; i++) step(70, 35, 15);
    for (int i = 0; i < 120; i++) step(50, 50, 50);
    for (int i = 0; i < 40; i++)  step(95, 10, 50);
    step(100, 0, 50);
    reset_in_update();
    for (int i = 0; i < 80; i++)  step(60, 40, 50);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
